// File: rtl/inst_queue.sv
// Instruction queue: circular FIFO between the fetcher and the decoder.
// Holds fetched instruction words with their PC and BTB prediction and
// presents the oldest entry to the decoder. A ROB misprediction clear
// empties the whole queue.
module inst_queue #(
  parameter int IQ_SIZE_LOG = 4
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        rdy_in,
  input  logic        IF_flag,
  input  logic [31:0] IF_inst,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_BTB_PC,
  input  logic        IF_BTB_predict,
  output logic        IQ_full,
  output logic        IQ_flag,
  output logic [31:0] IQ_inst,
  output logic [31:0] IQ_PC,
  output logic [31:0] IQ_BTB_PC,
  output logic        IQ_BTB_predict,
  input  logic        Dec_flag,
  input  logic        ROB_clear
);

  localparam int DEPTH = 1 << IQ_SIZE_LOG;
  localparam logic [IQ_SIZE_LOG:0]   FullCount = {1'b1, {IQ_SIZE_LOG{1'b0}}};
  localparam logic [IQ_SIZE_LOG:0]   CountOne  = {{IQ_SIZE_LOG{1'b0}}, 1'b1};
  localparam logic [IQ_SIZE_LOG-1:0] PtrOne    = {{(IQ_SIZE_LOG-1){1'b0}}, 1'b1};

  // Entry layout: {inst, PC, BTB_PC, predict}
  logic [96:0] entries_q [DEPTH];

  logic [IQ_SIZE_LOG-1:0] head_q, head_d;
  logic [IQ_SIZE_LOG-1:0] tail_q, tail_d;
  logic [IQ_SIZE_LOG:0]   count_q, count_d;

  logic        push;
  logic        pop;
  logic        pushEn;
  logic [96:0] headEntry;

  // Status flags and head presentation, forced to zero while empty
  always_comb begin
    IQ_flag        = (count_q != '0);
    IQ_full        = (count_q == FullCount);
    headEntry      = entries_q[head_q];
    IQ_inst        = '0;
    IQ_PC          = '0;
    IQ_BTB_PC      = '0;
    IQ_BTB_predict = 1'b0;
    if (IQ_flag) begin
      IQ_inst        = headEntry[96:65];
      IQ_PC          = headEntry[64:33];
      IQ_BTB_PC      = headEntry[32:1];
      IQ_BTB_predict = headEntry[0];
    end
  end

  // Pointer and occupancy next state: stall beats flush beats push/pop
  always_comb begin
    push    = IF_flag && !IQ_full;
    pop     = Dec_flag && IQ_flag;
    pushEn  = 1'b0;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (ROB_clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        pushEn = push;
        if (push) begin
          tail_d = tail_q + PtrOne;
        end
        if (pop) begin
          head_d = head_q + PtrOne;
        end
        case ({push, pop})
          2'b10:   count_d = count_q + CountOne;
          2'b01:   count_d = count_q - CountOne;
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Control state registers, cleared asynchronously
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk_in) begin
    if (pushEn) begin
      entries_q[tail_q] <= {IF_inst, IF_PC, IF_BTB_PC, IF_BTB_predict};
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random
// traffic, checked by a monitor against a queue-based reference model.
module tb_inst_queue;

  localparam int DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        rdy_in;
  logic        IF_flag;
  logic [31:0] IF_inst;
  logic [31:0] IF_PC;
  logic [31:0] IF_BTB_PC;
  logic        IF_BTB_predict;
  logic        IQ_full;
  logic        IQ_flag;
  logic [31:0] IQ_inst;
  logic [31:0] IQ_PC;
  logic [31:0] IQ_BTB_PC;
  logic        IQ_BTB_predict;
  logic        Dec_flag;
  logic        ROB_clear;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  // Reference model: entries the DUT should hold, oldest first
  logic [96:0] expQ [$];

  inst_queue #(.IQ_SIZE_LOG(4)) dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .rdy_in         (rdy_in),
    .IF_flag        (IF_flag),
    .IF_inst        (IF_inst),
    .IF_PC          (IF_PC),
    .IF_BTB_PC      (IF_BTB_PC),
    .IF_BTB_predict (IF_BTB_predict),
    .IQ_full        (IQ_full),
    .IQ_flag        (IQ_flag),
    .IQ_inst        (IQ_inst),
    .IQ_PC          (IQ_PC),
    .IQ_BTB_PC      (IQ_BTB_PC),
    .IQ_BTB_predict (IQ_BTB_predict),
    .Dec_flag       (Dec_flag),
    .ROB_clear      (ROB_clear)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [96:0] actual,
                             input logic [96:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; the model commits pushes/flushes after the edge
  task automatic applyStimulus(input logic ifF, input logic [31:0] inst,
                               input logic [31:0] pc, input logic [31:0] btb,
                               input logic pred, input logic dec,
                               input logic clr, input logic rdy);
    logic accept;
    @(negedge clk_in);
    IF_flag        = ifF;
    IF_inst        = inst;
    IF_PC          = pc;
    IF_BTB_PC      = btb;
    IF_BTB_predict = pred;
    Dec_flag       = dec;
    ROB_clear      = clr;
    rdy_in         = rdy;
    accept = rdy && !clr && ifF && (expQ.size() < DEPTH);
    @(posedge clk_in);
    #1;
    if (rdy && clr) expQ.delete();
    else if (accept) expQ.push_back({inst, pc, btb, pred});
  endtask

  task automatic pushPc(input logic [31:0] pc);
    applyStimulus(1'b1, 32'hA000_0000 ^ pc, pc, pc + 32'h40, pc[2], 1'b0, 1'b0, 1'b1);
  endtask

  task automatic popOne();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: just before each edge compare the head against the model and
  // retire the model head whenever the decoder consumes it
  initial begin
    logic [96:0] expHead;
    logic [96:0] actHead;
    @(posedge rst_n);
    while (!done) begin
      @(negedge clk_in);
      #4;
      if (done) break;
      expHead = (expQ.size() != 0) ? expQ[0] : '0;
      actHead = {IQ_inst, IQ_PC, IQ_BTB_PC, IQ_BTB_predict};
      checkOutput("IQ_flag", {96'd0, IQ_flag}, {96'd0, expQ.size() != 0});
      checkOutput("IQ_full", {96'd0, IQ_full}, {96'd0, expQ.size() == DEPTH});
      checkOutput("head", actHead, expHead);
      if (rst_n && rdy_in && !ROB_clear && Dec_flag && expQ.size() != 0)
        void'(expQ.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; rdy_in = 1'b1; IF_flag = 1'b0; IF_inst = '0; IF_PC = '0;
    IF_BTB_PC = '0; IF_BTB_predict = 1'b0; Dec_flag = 1'b0; ROB_clear = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;

    // Reset values straight out of reset
    #1;
    checkOutput("reset flag", {96'd0, IQ_flag}, 97'd0);
    checkOutput("reset full", {96'd0, IQ_full}, 97'd0);
    checkOutput("reset data", {IQ_inst, IQ_PC, IQ_BTB_PC, IQ_BTB_predict}, 97'd0);

    // Fill to full, drop a 17th push, then drain in order
    for (int k = 0; k < DEPTH; k++) pushPc(32'(k * 4));
    pushPc(32'h40);
    for (int k = 0; k < DEPTH + 1; k++) popOne();

    // Full with simultaneous push and pop: the push is rejected
    for (int k = 0; k < DEPTH; k++) pushPc(32'h300 + 32'(k * 4));
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h3F0, 32'h3F4, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    for (int k = 0; k < DEPTH; k++) popOne();

    // Wrap: start from pointer zero via a flush, then cross index 15->0
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) pushPc(32'h80 + 32'(k * 4));
    for (int k = 0; k < 10; k++) popOne();
    for (int k = 0; k < 12; k++) pushPc(32'h100 + 32'(k * 4));
    for (int k = 0; k < 12; k++) popOne();

    // Flush with push and pop requested the same cycle
    for (int k = 0; k < 5; k++) pushPc(32'h180 + 32'(k * 4));
    applyStimulus(1'b1, 32'h1111_1111, 32'h1F0, 32'h1F4, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0013, 32'h200, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    checkOutput("post-flush head inst", {65'd0, IQ_inst}, {65'd0, 32'h0000_0013});
    checkOutput("post-flush head PC", {65'd0, IQ_PC}, {65'd0, 32'h200});
    popOne();

    // Count==1 push+pop: new entry becomes head, still one entry
    pushPc(32'h400);
    applyStimulus(1'b1, 32'h0BAD_F00D, 32'h404, 32'h408, 1'b1, 1'b1, 1'b0, 1'b1);
    popOne();
    popOne();

    // Stall: rdy_in low freezes everything despite push and pop requests
    for (int k = 0; k < 3; k++) pushPc(32'h500 + 32'(k * 4));
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 32'h5555_5555, 32'h5F0, 32'h5F4, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) popOne();

    // Asynchronous reset mid-cycle with entries queued
    for (int k = 0; k < 4; k++) pushPc(32'h600 + 32'(k * 4));
    @(negedge clk_in);
    IF_flag = 1'b0; Dec_flag = 1'b0; ROB_clear = 1'b0; rdy_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset flag", {96'd0, IQ_flag}, 97'd0);
    checkOutput("async reset full", {96'd0, IQ_full}, 97'd0);
    checkOutput("async reset data", {IQ_inst, IQ_PC, IQ_BTB_PC, IQ_BTB_predict}, 97'd0);
    expQ.delete();
    @(negedge clk_in);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      applyStimulus($urandom_range(0, 9) < 6, $urandom, $urandom, $urandom,
                    1'($urandom), $urandom_range(0, 9) < 5,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 9) != 0);
    end
    for (int k = 0; k < DEPTH + 1; k++) popOne();

    done = 1'b1;
    @(negedge clk_in);
    #6;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
